// File: rtl/cdb_pkg.sv
// rtl/cdb_pkg.sv - shared types and helpers for the CDB writeback arbiter
package cdb_pkg;

  localparam int NUM_CDB_SRC = 3;
  localparam int CDB_PHYS_W  = 7;

  typedef enum logic [1:0] {
    SRC_ALU = 2'd0,
    SRC_MUL = 2'd1,
    SRC_DIV = 2'd2
  } cdb_src_e;

  typedef struct packed {
    logic [CDB_PHYS_W-1:0] phys_addr;
    logic [31:0]           value;
    logic [31:0]           exec_index;
  } cdb_entry_t;

  function automatic logic [1:0] rr_next(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/cdb_src_fifo.sv
// rtl/cdb_src_fifo.sv - per-source result FIFO with flush; head is the oldest entry
module cdb_src_fifo
  import cdb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic       push,
  input  logic       pop,
  input  cdb_entry_t din,
  output cdb_entry_t head,
  output logic       empty,
  output logic       full
);

  localparam int AW = $clog2(FIFO_DEPTH);

  cdb_entry_t    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  // Storage needs no reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(FIFO_DEPTH));

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin CDB writeback arbiter over ALU/MUL/DIV FIFOs; CDB_BYPASS_EN enables empty-FIFO bypass
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int PHYS_W     = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              alu_exec_done,
  input  logic [PHYS_W-1:0] alu_phys_addr,
  input  logic [31:0]       alu_exec_value,
  input  logic [31:0]       alu_exec_index,
  input  logic              mul_exec_done,
  input  logic [PHYS_W-1:0] mul_phys_addr,
  input  logic [31:0]       mul_exec_value,
  input  logic [31:0]       mul_exec_index,
  input  logic              div_exec_done,
  input  logic [PHYS_W-1:0] div_phys_addr,
  input  logic [31:0]       div_exec_value,
  input  logic [31:0]       div_exec_index,
  output logic              alu_ready,
  output logic              mul_ready,
  output logic              div_ready,
  output logic              cdb_valid,
  output logic [PHYS_W-1:0] cdb_phys_addr,
  output logic [31:0]       cdb_value,
  output logic [31:0]       cdb_exec_index,
  output logic [1:0]        cdb_src,
  output logic              overflow_err
);

  logic [NUM_CDB_SRC-1:0] done, empty, full, push, pop, cand;
  cdb_entry_t             in_e   [NUM_CDB_SRC];
  cdb_entry_t             head   [NUM_CDB_SRC];
  cdb_entry_t             cand_e [NUM_CDB_SRC];
  logic [1:0]             rr_ptr, win, idx;
  logic                   found;
  logic                   ovf_hit;

  assign done    = {div_exec_done, mul_exec_done, alu_exec_done};
  assign in_e[0] = '{phys_addr: alu_phys_addr, value: alu_exec_value, exec_index: alu_exec_index};
  assign in_e[1] = '{phys_addr: mul_phys_addr, value: mul_exec_value, exec_index: mul_exec_index};
  assign in_e[2] = '{phys_addr: div_phys_addr, value: div_exec_value, exec_index: div_exec_index};

  assign alu_ready = ~full[0];
  assign mul_ready = ~full[1];
  assign div_ready = ~full[2];

  for (genvar g = 0; g < NUM_CDB_SRC; g++) begin : g_fifo
    cdb_src_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .push  (push[g]),
      .pop   (pop[g]),
      .din   (in_e[g]),
      .head  (head[g]),
      .empty (empty[g]),
      .full  (full[g])
    );
  end

`ifdef CDB_BYPASS_EN
  // Only an empty FIFO may bypass, so per-source order is never broken.
  assign cand = ~empty | (empty & done & {NUM_CDB_SRC{~flush}});
  always_comb begin
    for (int i = 0; i < NUM_CDB_SRC; i++) cand_e[i] = empty[i] ? in_e[i] : head[i];
  end
`else
  assign cand = ~empty;
  always_comb begin
    for (int i = 0; i < NUM_CDB_SRC; i++) cand_e[i] = head[i];
  end
`endif

  always_comb begin
    found = 1'b0;
    win   = rr_ptr;
    idx   = rr_ptr;
    for (int k = 0; k < NUM_CDB_SRC; k++) begin
      if (!found && cand[idx]) begin
        found = 1'b1;
        win   = idx;
      end
      idx = rr_next(idx);
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CDB_SRC; i++) begin
      pop[i]  = found && (win == 2'(i)) && !empty[i] && !flush;
      push[i] = done[i] && !full[i] && !flush;
`ifdef CDB_BYPASS_EN
      if (found && (win == 2'(i)) && empty[i]) push[i] = 1'b0;
`endif
    end
  end

  assign ovf_hit = |(done & full) && !flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      cdb_valid      <= 1'b0;
      cdb_phys_addr  <= '0;
      cdb_value      <= '0;
      cdb_exec_index <= '0;
      cdb_src        <= SRC_ALU;
      rr_ptr         <= 2'd0;
      overflow_err   <= 1'b0;
    end else begin
      if (ovf_hit) overflow_err <= 1'b1;
      if (flush) begin
        cdb_valid <= 1'b0;
      end else begin
        cdb_valid <= found;
        if (found) begin
          cdb_phys_addr  <= cand_e[win].phys_addr;
          cdb_value      <= cand_e[win].value;
          cdb_exec_index <= cand_e[win].exec_index;
          cdb_src        <= win;
          rr_ptr         <= rr_next(win);
        end
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - scoreboard bench for cdb_arbiter
module tb_cdb_arbiter;
  import cdb_pkg::*;

  logic        clk = 1'b0;
  logic        reset, flush;
  logic        alu_exec_done, mul_exec_done, div_exec_done;
  logic [6:0]  alu_phys_addr, mul_phys_addr, div_phys_addr;
  logic [31:0] alu_exec_value, mul_exec_value, div_exec_value;
  logic [31:0] alu_exec_index, mul_exec_index, div_exec_index;
  logic        alu_ready, mul_ready, div_ready;
  logic        cdb_valid;
  logic [6:0]  cdb_phys_addr;
  logic [31:0] cdb_value, cdb_exec_index;
  logic [1:0]  cdb_src;
  logic        overflow_err;

  always #5 clk = ~clk;

  cdb_arbiter #(.FIFO_DEPTH(4), .PHYS_W(7)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .alu_exec_done(alu_exec_done), .alu_phys_addr(alu_phys_addr),
    .alu_exec_value(alu_exec_value), .alu_exec_index(alu_exec_index),
    .mul_exec_done(mul_exec_done), .mul_phys_addr(mul_phys_addr),
    .mul_exec_value(mul_exec_value), .mul_exec_index(mul_exec_index),
    .div_exec_done(div_exec_done), .div_phys_addr(div_phys_addr),
    .div_exec_value(div_exec_value), .div_exec_index(div_exec_index),
    .alu_ready(alu_ready), .mul_ready(mul_ready), .div_ready(div_ready),
    .cdb_valid(cdb_valid), .cdb_phys_addr(cdb_phys_addr), .cdb_value(cdb_value),
    .cdb_exec_index(cdb_exec_index), .cdb_src(cdb_src), .overflow_err(overflow_err)
  );

  typedef struct packed {
    logic [6:0]  phys;
    logic [31:0] value;
    logic [31:0] idx;
    logic [1:0]  src;
  } bcast_t;

  bcast_t exp_q[$];
  int     checks = 0;
  int     errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Monitor: every broadcast must match the oldest outstanding expectation.
  always @(negedge clk) begin : monitor
    bcast_t got, want;
    if (cdb_valid === 1'b1) begin
      got = '{cdb_phys_addr, cdb_value, cdb_exec_index, cdb_src};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL cdb_unexpected: got src=%0d phys=%h val=%h idx=%h want no broadcast",
                 got.src, got.phys, got.value, got.idx);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          errors++;
          $display("FAIL cdb_bcast: got src=%0d phys=%h val=%h idx=%h want src=%0d phys=%h val=%h idx=%h",
                   got.src, got.phys, got.value, got.idx, want.src, want.phys, want.value, want.idx);
        end
      end
    end
  end

  function automatic cdb_entry_t ent(input int s, input int k);
    cdb_entry_t e;
    e.phys_addr  = 7'(s * 20 + k);
    e.value      = 32'hA500_0000 + 32'(s * 65536 + k);
    e.exec_index = 32'(s * 256 + k);
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    alu_exec_done = 1'b0;
    mul_exec_done = 1'b0;
    div_exec_done = 1'b0;
  endtask

  task automatic drive(input int s, input cdb_entry_t e);
    case (s)
      0: begin alu_exec_done = 1'b1; alu_phys_addr = e.phys_addr; alu_exec_value = e.value; alu_exec_index = e.exec_index; end
      1: begin mul_exec_done = 1'b1; mul_phys_addr = e.phys_addr; mul_exec_value = e.value; mul_exec_index = e.exec_index; end
      default: begin div_exec_done = 1'b1; div_phys_addr = e.phys_addr; div_exec_value = e.value; div_exec_index = e.exec_index; end
    endcase
  endtask

  task automatic expect_b(input int s, input cdb_entry_t e);
    exp_q.push_back('{e.phys_addr, e.value, e.exec_index, 2'(s)});
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    clr();
    flush = 1'b0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_valid"}, 32'(cdb_valid), 32'd0);
    chk({tag, "_phys"}, 32'(cdb_phys_addr), 32'd0);
    chk({tag, "_value"}, cdb_value, 32'd0);
    chk({tag, "_index"}, cdb_exec_index, 32'd0);
    chk({tag, "_src"}, 32'(cdb_src), 32'd0);
    chk({tag, "_ovf"}, 32'(overflow_err), 32'd0);
    chk({tag, "_ready"}, 32'({div_ready, mul_ready, alu_ready}), 32'd7);
  endtask

  cdb_entry_t e1;

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1);
  end

  initial begin
    clr();
    alu_phys_addr = '0; mul_phys_addr = '0; div_phys_addr = '0;
    alu_exec_value = '0; mul_exec_value = '0; div_exec_value = '0;
    alu_exec_index = '0; mul_exec_index = '0; div_exec_index = '0;
    flush = 1'b0;
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    chk_reset_state("rst");

    // Single ALU result, latency and one-cycle pulse.
    e1 = '{phys_addr: 7'd5, value: 32'hDEAD_BEEF, exec_index: 32'd12};
    drive(0, e1);
    expect_b(0, e1);
    step();
    clr();
`ifdef CDB_BYPASS_EN
    chk("t1_valid_n1", 32'(cdb_valid), 32'd1);
`else
    chk("t1_valid_n1", 32'(cdb_valid), 32'd0);
    step();
    chk("t1_valid_n2", 32'(cdb_valid), 32'd1);
`endif
    chk("t1_src", 32'(cdb_src), 32'd0);
    step();
    chk("t1_valid_after", 32'(cdb_valid), 32'd0);
    idle(4);

    // All three at once from rr_ptr=0: ALU, MUL, DIV.
    do_reset();
    drive(0, '{phys_addr: 7'd10, value: 32'h1111_0001, exec_index: 32'd1});
    drive(1, '{phys_addr: 7'd11, value: 32'h2222_0002, exec_index: 32'd2});
    drive(2, '{phys_addr: 7'd12, value: 32'h3333_0003, exec_index: 32'd3});
    expect_b(0, '{phys_addr: 7'd10, value: 32'h1111_0001, exec_index: 32'd1});
    expect_b(1, '{phys_addr: 7'd11, value: 32'h2222_0002, exec_index: 32'd2});
    expect_b(2, '{phys_addr: 7'd12, value: 32'h3333_0003, exec_index: 32'd3});
    step();
    clr();
    idle(5);

    // rr_ptr back at 0: ALU beats MUL.
    drive(0, ent(0, 40)); drive(1, ent(1, 41));
    expect_b(0, ent(0, 40)); expect_b(1, ent(1, 41));
    step();
    clr();
    idle(5);

    // Rotation: MUL grant, then pending ALU and DIV go DIV first.
    drive(1, ent(1, 50));
    expect_b(1, ent(1, 50));
    step();
    clr();
    drive(0, ent(0, 51)); drive(2, ent(2, 52));
    expect_b(2, ent(2, 52)); expect_b(0, ent(0, 51));
    step();
    clr();
    idle(6);

    // Fill MUL under full contention (rr_ptr=1): grants cycle MUL, DIV, ALU.
    for (int k = 1; k <= 5; k++) begin
      expect_b(1, ent(1, k)); expect_b(2, ent(2, k)); expect_b(0, ent(0, k));
    end
    expect_b(1, ent(1, 6));
    for (int k = 1; k <= 5; k++) begin
      drive(0, ent(0, k)); drive(1, ent(1, k)); drive(2, ent(2, k));
      step();
    end
    clr();
    chk("fill_ready_mid", 32'({div_ready, mul_ready, alu_ready}), 32'b010);
    drive(1, ent(1, 6));
    step();
    clr();
    chk("fill_mul_ready", 32'(mul_ready), 32'd0);
    chk("fill_ovf_before", 32'(overflow_err), 32'd0);
    drive(1, ent(1, 7));
    step();
    clr();
    chk("fill_ovf_after", 32'(overflow_err), 32'd1);
    idle(16);
    chk("fill_drained", 32'(exp_q.size()), 32'd0);

    // Flush with three buffered and a DIV result in the flush cycle.
    drive(0, ent(0, 60)); drive(1, ent(1, 61)); drive(2, ent(2, 62));
    step();
    clr();
    flush = 1'b1;
    drive(2, ent(2, 63));
    step();
    flush = 1'b0;
    clr();
    chk("flush_valid", 32'(cdb_valid), 32'd0);
    chk("flush_ready", 32'({div_ready, mul_ready, alu_ready}), 32'd7);
    chk("flush_ovf", 32'(overflow_err), 32'd1);
    idle(6);

    // Reset mid-drain (rr_ptr=2): DIV broadcasts, ALU and MUL are discarded.
    drive(0, ent(0, 70)); drive(1, ent(1, 71)); drive(2, ent(2, 72));
    expect_b(2, ent(2, 72));
    step();
    clr();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_reset_state("mid_rst");
    idle(8);

    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
